// File: rtl/axis_signal_gen_v6_ctrl.sv
// Signal-generator control: snapshots waveform registers on each we_reg rising edge
// into a descriptor FIFO and streams each descriptor REP+1 times over an AXIS master.
module axis_signal_gen_v6_ctrl #(
  parameter int FREQW  = 32,
  parameter int PHASEW = 32,
  parameter int ADDRW  = 16,
  parameter int GAINW  = 16,
  parameter int NSAMPW = 16,
  parameter int REPW   = 8,
  parameter int DEPTH  = 8,
  parameter int TDATAW = 128
) (
  input  logic                       aclk,
  input  logic                       rst,
  input  logic [FREQW-1:0]           freq_reg,
  input  logic [PHASEW-1:0]          phase_reg,
  input  logic [ADDRW-1:0]           addr_reg,
  input  logic [GAINW-1:0]           gain_reg,
  input  logic [NSAMPW-1:0]          nsamp_reg,
  input  logic [1:0]                 outsel_reg,
  input  logic                       mode_reg,
  input  logic                       stdysel_reg,
  input  logic                       phrst_reg,
  input  logic [REPW-1:0]            rep_reg,
  input  logic                       we_reg,
  input  logic                       flush,
  output logic                       m_axis_tvalid,
  input  logic                       m_axis_tready,
  output logic [TDATAW-1:0]          m_axis_tdata,
  output logic [$clog2(DEPTH):0]     fifo_count,
  output logic                       ovf,
  output logic                       busy
);

  localparam int DESCW     = FREQW + PHASEW + ADDRW + GAINW + NSAMPW + 5;
  localparam int ENTW      = DESCW + REPW;
  localparam int AW        = $clog2(DEPTH);
  localparam int CW        = AW + 1;
  localparam int PHRST_BIT = DESCW - 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

  generate
    if (DESCW > TDATAW) begin : g_tdata_too_narrow
      $error("axis_signal_gen_v6_ctrl: descriptor fields exceed TDATAW");
    end
    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("axis_signal_gen_v6_ctrl: DEPTH must be a power of 2 and >= 2");
    end
  endgenerate

  typedef enum logic {IDLE, SEND} state_t;

  state_t              state_q, state_d;
  logic                we_d_q;
  logic [ENTW-1:0]     mem_q [DEPTH];
  logic [AW-1:0]       wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]       count_q, count_d;
  logic [REPW-1:0]     rep_cnt_q, rep_cnt_d;
  logic                tvalid_q, tvalid_d;
  logic [TDATAW-1:0]   tdata_q, tdata_d;
  logic                ovf_q, ovf_d;

  logic                push_req, push_ok, pop, hs, fifo_empty;
  logic [ENTW-1:0]     entry_in, head;

  always_comb begin
    push_req   = we_reg & ~we_d_q;
    entry_in   = {rep_reg, phrst_reg, stdysel_reg, mode_reg, outsel_reg,
                  nsamp_reg, gain_reg, addr_reg, phase_reg, freq_reg};
    head       = mem_q[rd_ptr_q];
    fifo_empty = (count_q == '0);
    hs         = tvalid_q & m_axis_tready;

    state_d    = state_q;
    rep_cnt_d  = rep_cnt_q;
    tvalid_d   = tvalid_q;
    tdata_d    = tdata_q;
    pop        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (!fifo_empty && !flush) begin
          pop       = 1'b1;
          tdata_d   = TDATAW'(head[DESCW-1:0]);
          rep_cnt_d = head[ENTW-1:DESCW];
          tvalid_d  = 1'b1;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (hs) begin
          if (rep_cnt_q != '0 && !flush) begin
            // Repeats replay the same descriptor; only the first beat may reset phase.
            rep_cnt_d          = rep_cnt_q - REPW'(1);
            tdata_d[PHRST_BIT] = 1'b0;
          end else if (!fifo_empty && !flush) begin
            pop       = 1'b1;
            tdata_d   = TDATAW'(head[DESCW-1:0]);
            rep_cnt_d = head[ENTW-1:DESCW];
          end else begin
            tvalid_d = 1'b0;
            state_d  = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) rep_cnt_d = '0;

    // A full FIFO still accepts when the head leaves in the same cycle; flush discards.
    push_ok  = push_req & ~flush & ((count_q != DEPTH_C) | pop);
    wr_ptr_d = wr_ptr_q + AW'(push_ok);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    count_d  = count_q;
    unique case ({push_ok, pop})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    ovf_d = ovf_q | (push_req & ~push_ok);

    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      ovf_d    = 1'b0;
    end
  end

  always_ff @(posedge aclk) begin
    if (rst) begin
      state_q   <= IDLE;
      we_d_q    <= 1'b1;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rep_cnt_q <= '0;
      tvalid_q  <= 1'b0;
      tdata_q   <= '0;
      ovf_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      we_d_q    <= we_reg;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rep_cnt_q <= rep_cnt_d;
      tvalid_q  <= tvalid_d;
      tdata_q   <= tdata_d;
      ovf_q     <= ovf_d;
    end
  end

  always_ff @(posedge aclk) begin
    if (push_ok && !rst) mem_q[wr_ptr_q] <= entry_in;
  end

  assign m_axis_tvalid = tvalid_q;
  assign m_axis_tdata  = tdata_q;
  assign fifo_count    = count_q;
  assign ovf           = ovf_q;
  assign busy          = (state_q == SEND) | (count_q != '0);

endmodule

// File: tb/tb_axis_signal_gen_v6_ctrl.sv
// Directed bench for axis_signal_gen_v6_ctrl with default parameters.
module tb_axis_signal_gen_v6_ctrl;

  logic         aclk = 1'b0;
  logic         rst;
  logic [31:0]  freq_reg, phase_reg;
  logic [15:0]  addr_reg, gain_reg, nsamp_reg;
  logic [1:0]   outsel_reg;
  logic         mode_reg, stdysel_reg, phrst_reg;
  logic [7:0]   rep_reg;
  logic         we_reg, flush;
  logic         m_axis_tvalid, m_axis_tready;
  logic [127:0] m_axis_tdata;
  logic [3:0]   fifo_count;
  logic         ovf, busy;

  int n_checks = 0;
  int n_errors = 0;
  logic [127:0] beats [$];
  logic         stall_prev = 1'b0;
  logic         rst_prev   = 1'b1;
  logic [127:0] data_prev  = '0;

  always #5 aclk = ~aclk;

  axis_signal_gen_v6_ctrl dut (
    .aclk(aclk), .rst(rst), .freq_reg(freq_reg), .phase_reg(phase_reg),
    .addr_reg(addr_reg), .gain_reg(gain_reg), .nsamp_reg(nsamp_reg),
    .outsel_reg(outsel_reg), .mode_reg(mode_reg), .stdysel_reg(stdysel_reg),
    .phrst_reg(phrst_reg), .rep_reg(rep_reg), .we_reg(we_reg), .flush(flush),
    .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready),
    .m_axis_tdata(m_axis_tdata), .fifo_count(fifo_count), .ovf(ovf), .busy(busy)
  );

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge aclk);
    #1;
  endtask

  task automatic pulse_we();
    we_reg = 1'b1;
    tick();
    we_reg = 1'b0;
    tick();
  endtask

  // Beat collection and AXIS hold rule, both sampled mid-cycle.
  always @(negedge aclk) begin
    if (m_axis_tvalid && m_axis_tready) beats.push_back(m_axis_tdata);
    if (stall_prev && !rst_prev) begin
      check("hold_valid", {127'b0, m_axis_tvalid}, 128'd1);
      check("hold_data", m_axis_tdata, data_prev);
    end
    stall_prev <= m_axis_tvalid & ~m_axis_tready;
    data_prev  <= m_axis_tdata;
    rst_prev   <= rst;
  end

  initial begin
    rst = 1'b1; we_reg = 1'b1; flush = 1'b0; m_axis_tready = 1'b1;
    freq_reg = '0; phase_reg = '0; addr_reg = '0; gain_reg = '0; nsamp_reg = '0;
    outsel_reg = '0; mode_reg = 1'b0; stdysel_reg = 1'b0; phrst_reg = 1'b0; rep_reg = '0;

    // Reset state, with we_reg held high across release
    tick(3);
    check("rst_tvalid", {127'b0, m_axis_tvalid}, 128'd0);
    check("rst_tdata", m_axis_tdata, 128'd0);
    check("rst_count", {124'b0, fifo_count}, 128'd0);
    check("rst_ovf", {127'b0, ovf}, 128'd0);
    check("rst_busy", {127'b0, busy}, 128'd0);
    rst = 1'b0;
    tick(4);
    check("we_high_no_capture_count", {124'b0, fifo_count}, 128'd0);
    check("we_high_no_capture_valid", {127'b0, m_axis_tvalid}, 128'd0);
    check("we_high_no_capture_beats", beats.size(), 128'd0);
    we_reg = 1'b0;
    tick();

    // Single descriptor and latency
    freq_reg = 32'd100; phase_reg = 32'd23; addr_reg = 16'd126; gain_reg = 16'd10000;
    nsamp_reg = 16'd345; outsel_reg = 2'd1; rep_reg = 8'd0;
    beats.delete();
    we_reg = 1'b1;
    tick();
    we_reg = 1'b0;
    check("lat_n1_valid", {127'b0, m_axis_tvalid}, 128'd0);
    tick();
    check("lat_n2_valid", {127'b0, m_axis_tvalid}, 128'd1);
    check("single_tdata", m_axis_tdata,
          {11'b0, 1'b0, 1'b0, 1'b0, 2'd1, 16'd345, 16'd10000, 16'd126, 32'd23, 32'd100});
    check("single_freq", {96'b0, m_axis_tdata[31:0]}, 128'd100);
    check("single_addr", {112'b0, m_axis_tdata[79:64]}, 128'd126);
    check("single_nsamp", {112'b0, m_axis_tdata[111:96]}, 128'd345);
    check("single_outsel", {126'b0, m_axis_tdata[113:112]}, 128'd1);
    tick();
    check("single_done_valid", {127'b0, m_axis_tvalid}, 128'd0);
    tick(4);
    check("single_beats", beats.size(), 128'd1);
    check("single_busy", {127'b0, busy}, 128'd0);

    // Repeat with phase reset on first beat only
    freq_reg = 32'd7; rep_reg = 8'd3; phrst_reg = 1'b1;
    beats.delete();
    pulse_we();
    tick(8);
    phrst_reg = 1'b0; rep_reg = 8'd0;
    check("rep_beats", beats.size(), 128'd4);
    for (int i = 0; i < 4 && i < beats.size(); i++) begin
      check($sformatf("rep_freq%0d", i), {96'b0, beats[i][31:0]}, 128'd7);
      check($sformatf("rep_phrst%0d", i), {127'b0, beats[i][116]}, (i == 0) ? 128'd1 : 128'd0);
      check($sformatf("rep_fields%0d", i), {12'b0, beats[i][115:0]}, {12'b0, beats[0][115:0]});
    end

    // Backpressure: tready low 3 / high 5 while 5 descriptors arrive
    beats.delete();
    fork
      begin
        for (int k = 0; k < 6; k++) begin
          m_axis_tready = 1'b0;
          tick(3);
          m_axis_tready = 1'b1;
          tick(5);
        end
      end
      begin
        for (int k = 1; k <= 5; k++) begin
          freq_reg = k;
          pulse_we();
        end
      end
    join
    m_axis_tready = 1'b1;
    tick(10);
    check("bp_beats", beats.size(), 128'd5);
    for (int i = 0; i < 5 && i < beats.size(); i++)
      check($sformatf("bp_order%0d", i), {96'b0, beats[i][31:0]}, i + 1);

    // Overflow: 10 descriptors with the sink stalled
    m_axis_tready = 1'b0;
    beats.delete();
    for (int k = 1; k <= 10; k++) begin
      freq_reg = k;
      pulse_we();
    end
    tick(2);
    check("ovf_count", {124'b0, fifo_count}, 128'd8);
    check("ovf_flag", {127'b0, ovf}, 128'd1);
    check("ovf_busy", {127'b0, busy}, 128'd1);
    check("ovf_head", {96'b0, m_axis_tdata[31:0]}, 128'd1);
    m_axis_tready = 1'b1;
    tick(15);
    check("ovf_beats", beats.size(), 128'd9);
    for (int i = 0; i < 9 && i < beats.size(); i++)
      check($sformatf("ovf_order%0d", i), {96'b0, beats[i][31:0]}, i + 1);
    check("ovf_sticky", {127'b0, ovf}, 128'd1);
    check("ovf_drained", {124'b0, fifo_count}, 128'd0);

    // Flush with a push in the same cycle; held beat has pending repeats
    m_axis_tready = 1'b0;
    for (int k = 11; k <= 14; k++) begin
      freq_reg = k;
      rep_reg  = (k == 11) ? 8'd2 : 8'd0;
      pulse_we();
    end
    rep_reg = 8'd0;
    tick();
    check("pre_flush_count", {124'b0, fifo_count}, 128'd3);
    freq_reg = 32'd99;
    flush = 1'b1; we_reg = 1'b1;
    tick();
    flush = 1'b0; we_reg = 1'b0;
    check("flush_count", {124'b0, fifo_count}, 128'd0);
    check("flush_ovf", {127'b0, ovf}, 128'd0);
    check("flush_hold_valid", {127'b0, m_axis_tvalid}, 128'd1);
    check("flush_hold_freq", {96'b0, m_axis_tdata[31:0]}, 128'd11);
    tick(2);
    beats.delete();
    m_axis_tready = 1'b1;
    tick(10);
    check("flush_beats", beats.size(), 128'd1);
    if (beats.size() > 0) check("flush_beat_freq", {96'b0, beats[0][31:0]}, 128'd11);
    check("flush_idle_busy", {127'b0, busy}, 128'd0);

    // Mid-operation reset drops an outstanding beat
    m_axis_tready = 1'b0;
    freq_reg = 32'd55;
    pulse_we();
    pulse_we();
    check("mid_pre_valid", {127'b0, m_axis_tvalid}, 128'd1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    check("mid_rst_valid", {127'b0, m_axis_tvalid}, 128'd0);
    check("mid_rst_count", {124'b0, fifo_count}, 128'd0);
    check("mid_rst_busy", {127'b0, busy}, 128'd0);
    tick(3);
    check("mid_rst_stays_idle", {127'b0, m_axis_tvalid}, 128'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
